// File: rtl/serial_mac_pkg.sv
// serial_mac shared types: FSM states, default widths
// and signed clamp limits used by the saturating narrowers.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int DATA_W_D   = 16;
  localparam int WEIGHT_W_D = 16;
  localparam int FRAC_W_D   = 8;
  localparam int ACC_W_D    = 40;

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/serial_mac_if.sv
// serial_mac operand/result bundle; master drives the
// operation, slave is the MAC itself.
interface serial_mac_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_D
);

  logic              start;
  logic [DATA_W-1:0] input_neuron;
  logic              weight_bit;
  logic              weight_valid;
  logic              clear_acc;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] acc_out;
  logic              sat;

  modport master (
    output start, input_neuron,
    output weight_bit, weight_valid,
    output clear_acc,
    input  busy, done, product,
    input  acc_out, sat
  );

  modport slave (
    input  start, input_neuron,
    input  weight_bit, weight_valid,
    input  clear_acc,
    output busy, done, product,
    output acc_out, sat
  );

endinterface

// File: rtl/sat_narrow.sv
// Signed saturating narrower IN_W -> OUT_W; clamp
// reports that the input fell outside the output range.
module sat_narrow
  import mac_pkg::*;
#(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamp
);

  localparam logic signed [IN_W-1:0] HI =
    IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] LO =
    IN_W'(sat_min(OUT_W));

  always_comb begin
    clamp = 1'b0;
    dout  = din[OUT_W-1:0];
    if (din > HI) begin
      clamp = 1'b1;
      dout  = HI[OUT_W-1:0];
    end else if (din < LO) begin
      clamp = 1'b1;
      dout  = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/serial_mac.sv
// Bit-serial signed multiply-accumulate: weight arrives
// LSB first, product is rescaled, saturated and accumulated.
module serial_mac
  import mac_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int WEIGHT_W = WEIGHT_W_D,
  parameter int FRAC_W   = FRAC_W_D,
  parameter int ACC_W    = ACC_W_D,
  parameter bit SIGNED   = 1'b1
) (
  input logic         clk,
  input logic         reset,
  serial_mac_if.slave bus
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int CNT_W  =
    (WEIGHT_W > 1) ? $clog2(WEIGHT_W) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WEIGHT_W - 1);

  state_t                    state;
  logic signed [PROD_W-1:0]  op;
  logic signed [PROD_W-1:0]  partial;
  logic signed [PROD_W-1:0]  op_sh;
  logic signed [PROD_W-1:0]  scaled;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]          cnt;
  logic signed [DATA_W-1:0]  p_sat;
  logic signed [DATA_W-1:0]  a_sat;
  logic                      p_clamp;
  logic                      a_clamp;
  logic                      last;

  assign last     = (cnt == LAST);
  assign op_sh    = op << cnt;
  assign scaled   = partial >>> FRAC_W;
  // A clear coinciding with FINISH wins over the old sum.
  assign acc_base = bus.clear_acc ? '0 : acc;
  assign acc_next = acc_base + ACC_W'(scaled);

  sat_narrow #(.IN_W(PROD_W), .OUT_W(DATA_W)) u_p_sat (
    .din   (scaled),
    .dout  (p_sat),
    .clamp (p_clamp)
  );

  sat_narrow #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_a_sat (
    .din   (acc_next),
    .dout  (a_sat),
    .clamp (a_clamp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op          <= '0;
      partial     <= '0;
      cnt         <= '0;
      acc         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
      bus.acc_out <= '0;
      bus.sat     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.clear_acc) begin
        acc         <= '0;
        bus.acc_out <= '0;
        bus.sat     <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op       <= PROD_W'($signed(bus.input_neuron));
            partial  <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.weight_valid) begin
            if (bus.weight_bit) begin
              if (SIGNED && last)
                partial <= partial - op_sh;
              else
                partial <= partial + op_sh;
            end
            cnt <= cnt + 1'b1;
            if (last) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end
          end
        end
        FINISH: begin
          bus.product <= p_sat;
          acc         <= acc_next;
          bus.acc_out <= a_sat;
          bus.sat     <= (bus.clear_acc ? 1'b0 : bus.sat)
                         | p_clamp | a_clamp;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mac.sv
// Bench for serial_mac: directed scenarios plus random
// operations against a plain-arithmetic MAC model.
module tb_serial_mac;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_mac_if #(.DATA_W(16)) bus ();

  serial_mac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  longint      m_acc = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_aout = '0;
  bit          m_sat = 1'b0;

  function automatic longint clamp16(input longint v,
                                     output bit c);
    c = 1'b0;
    if (v > 32767) begin
      c = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      c = 1'b1;
      return -32768;
    end
    return v;
  endfunction

  function automatic longint wrap40(input longint v);
    longint m;
    m = v & ((longint'(1) << 40) - 1);
    if (m[39]) m = m - (longint'(1) << 40);
    return m;
  endfunction

  task automatic model_op(input logic [15:0] a,
                          input logic [15:0] w,
                          input bit clr);
    longint p, s, q;
    bit c1, c2;
    p = longint'($signed(a)) * longint'($signed(w));
    s = p >>> 8;
    if (clr) begin
      m_acc = 0;
      m_sat = 1'b0;
    end
    q = clamp16(s, c1);
    m_prod = q[15:0];
    m_acc = wrap40(m_acc + s);
    q = clamp16(m_acc, c2);
    m_aout = q[15:0];
    m_sat = m_sat | c1 | c2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.input_neuron = '0;
    bus.weight_bit = 1'b0;
    bus.weight_valid = 1'b0;
    bus.clear_acc = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] w,
                        input int st_at,
                        input int st_len,
                        input bit clr_fin,
                        input bit poke,
                        input string tag);
    int c, n, exp_lat;
    exp_lat = 17 + ((st_at < 16) ? st_len : 0);
    bus.start = 1'b1;
    bus.input_neuron = a;
    tick();
    bus.start = 1'b0;
    bus.input_neuron = 16'($urandom);
    c = 1;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_start: got %b want 1",
               tag, bus.busy);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == st_at) begin
        for (int k = 0; k < st_len; k++) begin
          bus.weight_valid = 1'b0;
          bus.weight_bit = 1'($urandom);
          if (poke) begin
            bus.start = 1'b1;
            bus.input_neuron = 16'h7fff;
          end
          tick();
          c++;
          bus.start = 1'b0;
        end
      end
      bus.weight_valid = 1'b1;
      bus.weight_bit = w[i];
      tick();
      c++;
      if (i < 15) begin
        n_cmp++;
        if (bus.done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s early_done: bit %0d got %b",
                   tag, i, bus.done);
        end
      end
    end
    bus.weight_valid = 1'b0;
    bus.weight_bit = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      tick();
      c++;
      n++;
    end
    n_cmp++;
    if (bus.done !== 1'b1 || c != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (done=%b) want %0d",
               tag, c, bus.done, exp_lat);
    end
    model_op(a, w, clr_fin);
    bus.clear_acc = clr_fin;
    tick();
    bus.clear_acc = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s end_flags: done=%b busy=%b want 0 0",
               tag, bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.product !== m_prod) begin
      n_bad++;
      $display("FAIL %s product: got %h want %h",
               tag, bus.product, m_prod);
    end
    n_cmp++;
    if (bus.acc_out !== m_aout) begin
      n_bad++;
      $display("FAIL %s acc_out: got %h want %h",
               tag, bus.acc_out, m_aout);
    end
    n_cmp++;
    if (bus.sat !== m_sat) begin
      n_bad++;
      $display("FAIL %s sat: got %b want %b",
               tag, bus.sat, m_sat);
    end
  endtask

  task automatic do_clear(input string tag);
    bus.clear_acc = 1'b1;
    tick();
    bus.clear_acc = 1'b0;
    m_acc = 0;
    m_aout = '0;
    m_sat = 1'b0;
    n_cmp++;
    if (bus.acc_out !== 16'h0 || bus.sat !== 1'b0 ||
        bus.product !== m_prod) begin
      n_bad++;
      $display("FAIL %s clear: acc=%h sat=%b prod=%h want 0 0 %h",
               tag, bus.acc_out, bus.sat, bus.product, m_prod);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({bus.busy, bus.done, bus.sat} !== 3'b000 ||
        bus.product !== 16'h0 || bus.acc_out !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state: b=%b d=%b s=%b p=%h a=%h",
               bus.busy, bus.done, bus.sat,
               bus.product, bus.acc_out);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_op(16'h1001, 16'h0300, 99, 0, 1'b0, 1'b0, "basic");
    n_cmp++;
    if (bus.product !== 16'h3003 || bus.acc_out !== 16'h3003) begin
      n_bad++;
      $display("FAIL basic_lit: p=%h a=%h want 3003 3003",
               bus.product, bus.acc_out);
    end
  endtask

  task automatic test_negative();
    run_op(16'hff00, 16'h0200, 99, 0, 1'b0, 1'b0, "neg");
    n_cmp++;
    if (bus.product !== 16'hfe00 || bus.acc_out !== 16'h2e03) begin
      n_bad++;
      $display("FAIL neg_lit: p=%h a=%h want fe00 2e03",
               bus.product, bus.acc_out);
    end
  endtask

  task automatic test_saturation();
    do_clear("sat_pre");
    run_op(16'h7fff, 16'h7fff, 99, 0, 1'b0, 1'b0, "sat");
    n_cmp++;
    if (bus.product !== 16'h7fff || bus.sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_lit: p=%h s=%b want 7fff 1",
               bus.product, bus.sat);
    end
    do_clear("sat_post");
  endtask

  task automatic test_stall();
    run_op(16'h1001, 16'h0300, 6, 3, 1'b0, 1'b1, "stall");
    n_cmp++;
    if (bus.product !== 16'h3003) begin
      n_bad++;
      $display("FAIL stall_lit: p=%h want 3003", bus.product);
    end
  endtask

  task automatic test_clear_finish();
    do_clear("cf_pre");
    run_op(16'h1001, 16'h0300, 99, 0, 1'b0, 1'b0, "cf_a");
    run_op(16'h0100, 16'h0100, 99, 0, 1'b1, 1'b0, "cf_b");
    n_cmp++;
    if (bus.acc_out !== 16'h0100) begin
      n_bad++;
      $display("FAIL cf_lit: acc=%h want 0100", bus.acc_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, w;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
      w = 16'($urandom);
      if (k % 3 == 0) w = 16'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) do_clear("rnd_clr");
      repeat ($urandom_range(0, 2)) tick();
      run_op(a, w, $urandom_range(0, 20),
             $urandom_range(0, 4),
             ($urandom_range(0, 5) == 0), 1'b1, "rnd");
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    w = 16'h0300;
    bus.start = 1'b1;
    bus.input_neuron = 16'h1001;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.weight_valid = 1'b1;
      bus.weight_bit = w[i];
      tick();
    end
    bus.weight_bit = w[7];
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.sat} !== 3'b000 ||
        bus.product !== 16'h0 || bus.acc_out !== 16'h0) begin
      n_bad++;
      $display("FAIL async_rst: b=%b d=%b s=%b p=%h a=%h",
               bus.busy, bus.done, bus.sat,
               bus.product, bus.acc_out);
    end
    m_acc = 0;
    m_prod = '0;
    m_aout = '0;
    m_sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        #3;
        reset = 1'b1;
      end
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_nodone: d=%b b=%b want 0 0",
                 bus.done, bus.busy);
      end
    end
    bus.weight_valid = 1'b0;
    run_op(16'h1001, 16'h0300, 99, 0, 1'b0, 1'b0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_stall();
    test_clear_finish();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
